// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: instruction formats, opcodes and
// the decoded bundle stored in the stage FIFO.
package decode_pkg;

   localparam int XLEN_P = 32;

   typedef enum logic [2:0] {
      T_R  = 3'd0,
      T_I  = 3'd1,
      T_S  = 3'd2,
      T_SB = 3'd3,
      T_UJ = 3'd4,
      T_U  = 3'd5
   } inst_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      inst_t             inst_type;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [XLEN_P-1:0] imm;
      logic [6:0]        opcode;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic              illegal;
   } decoded_t;

   // Legal funct3/funct7 pairs for the OP (register-register) opcode.
   function automatic logic r_legal(input logic [2:0] f3, input logic [6:0] f7,
                                    input logic muldiv);
      r_legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                (muldiv && (f7 == 7'b0000001));
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: raw instruction to decoded_t bundle.
// Define DECODE_MULDIV_EN to accept the RV32M funct7=0000001 encodings.
module decode_comb
   import decode_pkg::*;
(
   input  logic [31:0] inst,
   output decoded_t    dec
);

`ifdef DECODE_MULDIV_EN
   localparam logic MULDIV = 1'b1;
`else
   localparam logic MULDIV = 1'b0;
`endif

   logic [2:0] f3;
   logic [6:0] f7;

   assign f3 = inst[14:12];
   assign f7 = inst[31:25];

   always_comb begin
      dec        = '0;
      dec.opcode = inst[6:0];
      dec.funct3 = f3;
      dec.funct7 = f7;
      case (inst[6:0])
         OPC_OP: begin
            dec.inst_type = T_R;
            dec.rs1       = inst[19:15];
            dec.rs2       = inst[24:20];
            dec.rd        = inst[11:7];
            dec.illegal   = ~r_legal(f3, f7, MULDIV);
         end
         OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
            dec.inst_type = T_I;
            dec.rs1       = inst[19:15];
            dec.rd        = inst[11:7];
            dec.imm       = {{20{inst[31]}}, inst[31:20]};
            // shift immediates keep funct7 to tell SRLI from SRAI
            if (!((inst[6:0] == OPC_OPIMM) && ((f3 == 3'b001) || (f3 == 3'b101))))
               dec.funct7 = '0;
         end
         OPC_STORE: begin
            dec.inst_type = T_S;
            dec.rs1       = inst[19:15];
            dec.rs2       = inst[24:20];
            dec.imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            dec.funct7    = '0;
         end
         OPC_BRANCH: begin
            dec.inst_type = T_SB;
            dec.rs1       = inst[19:15];
            dec.rs2       = inst[24:20];
            dec.imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                             inst[11:8], 1'b0};
            dec.funct7    = '0;
         end
         OPC_JAL: begin
            dec.inst_type = T_UJ;
            dec.rd        = inst[11:7];
            dec.imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                             inst[30:21], 1'b0};
            dec.funct3    = '0;
            dec.funct7    = '0;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.inst_type = T_U;
            dec.rd        = inst[11:7];
            dec.imm       = {inst[31:12], 12'b0};
            dec.funct3    = '0;
            dec.funct7    = '0;
         end
         default: begin
            dec.inst_type = T_R;
            dec.illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and a small FIFO of
// decoded bundles. Define DECODE_MULDIV_EN to treat RV32M encodings as legal.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       inst_type,
   output logic [19:0]      control_out,
   output logic             illegal,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   decoded_t         dec_p0;
   decoded_t         mem [DEPTH];
   decoded_t         head_p1;
   decoded_t         head_nx;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_after_pop;
   logic             push;
   logic             pop;
   logic             load_head;

   // Stage 0: decode the incoming instruction
   decode_comb u_decode_comb (
      .inst (inst),
      .dec  (dec_p0)
   );

   assign in_ready  = ~rst & (cnt != CNT_W'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // The head register is reloaded with whatever will be at the front after
   // this edge; when the FIFO drains it keeps the last popped bundle.
   always_comb begin
      rd_ptr_nx     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      cnt_after_pop = cnt - CNT_W'(pop);
      head_nx       = (cnt_after_pop == '0) ? dec_p0 : mem[rd_ptr_nx];
      load_head     = ~flush & (push | (cnt_after_pop != '0));
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= dec_p0;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr_nx;
         cnt    <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Stage 1: head bundle presented to the consumer
   always_ff @(posedge clk) begin
      if (rst)
         head_p1 <= '0;
      else if (load_head)
         head_p1 <= head_nx;
   end

   assign rs1         = head_p1.rs1;
   assign rs2         = head_p1.rs2;
   assign rd          = head_p1.rd;
   assign imm         = head_p1.imm;
   assign inst_type   = head_p1.inst_type;
   assign control_out = {head_p1.inst_type, head_p1.opcode, head_p1.funct3, head_p1.funct7};
   assign illegal     = head_p1.illegal;
   assign count       = cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles are queued on accept
// and compared when the stage hands them out.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inst;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [2:0]  inst_type;
   logic [19:0] control_out;
   logic        illegal;
   logic [1:0]  count;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .inst        (inst),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .imm         (imm),
      .inst_type   (inst_type),
      .control_out (control_out),
      .illegal     (illegal),
      .count       (count)
   );

   typedef struct packed {
      logic [2:0]  t;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [19:0] ctrl;
      logic        ill;
   } exp_t;

`ifdef DECODE_MULDIV_EN
   localparam logic MUL_ILL = 1'b0;
`else
   localparam logic MUL_ILL = 1'b1;
`endif

   exp_t        sb [$];
   exp_t        cur_exp;
   logic [31:0] tinst [13];
   exp_t        texp  [13];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        rand_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] t, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] d, input logic [31:0] im,
                               input logic [19:0] c, input logic il);
      exp_t e;
      e.t = t; e.rs1 = r1; e.rs2 = r2; e.rd = d; e.imm = im; e.ctrl = c; e.ill = il;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid)
            check("orphan_bundle", (sb.size() != 0), 1);
         if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("inst_type", inst_type, e.t);
            check("rs1", rs1, e.rs1);
            check("rs2", rs2, e.rs2);
            check("rd", rd, e.rd);
            check("imm", imm, e.imm);
            check("control_out", control_out, e.ctrl);
            check("illegal", illegal, e.ill);
         end
         if (in_valid && in_ready)
            sb.push_back(cur_exp);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy)
         out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int idx);
      bit ok;
      ok       = 1'b0;
      inst     = tinst[idx];
      cur_exp  = texp[idx];
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (in_ready) begin
            step();
            ok = 1'b1;
            break;
         end
         step();
      end
      in_valid = 1'b0;
      if (!ok)
         check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (count == 0)
            break;
         step();
      end
      check("drain_count", count, 0);
      check("drain_sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tinst[0]  = 32'hFFF08293; texp[0]  = mk(3'd1, 5'd1, 5'd0, 5'd5,  32'hFFFFFFFF, {3'd1, 7'h13, 3'd0, 7'h00}, 1'b0);
      tinst[1]  = 32'hFE208EE3; texp[1]  = mk(3'd3, 5'd1, 5'd2, 5'd0,  32'hFFFFFFFC, {3'd3, 7'h63, 3'd0, 7'h00}, 1'b0);
      tinst[2]  = 32'h001000EF; texp[2]  = mk(3'd4, 5'd0, 5'd0, 5'd1,  32'h00000800, {3'd4, 7'h6F, 3'd0, 7'h00}, 1'b0);
      tinst[3]  = 32'h022081B3; texp[3]  = mk(3'd0, 5'd1, 5'd2, 5'd3,  32'h00000000, {3'd0, 7'h33, 3'd0, 7'h01}, MUL_ILL);
      tinst[4]  = 32'h0000007F; texp[4]  = mk(3'd0, 5'd0, 5'd0, 5'd0,  32'h00000000, {3'd0, 7'h7F, 3'd0, 7'h00}, 1'b1);
      tinst[5]  = 32'h402081B3; texp[5]  = mk(3'd0, 5'd1, 5'd2, 5'd3,  32'h00000000, {3'd0, 7'h33, 3'd0, 7'h20}, 1'b0);
      tinst[6]  = 32'h402091B3; texp[6]  = mk(3'd0, 5'd1, 5'd2, 5'd3,  32'h00000000, {3'd0, 7'h33, 3'd1, 7'h20}, 1'b1);
      tinst[7]  = 32'h123453B7; texp[7]  = mk(3'd5, 5'd0, 5'd0, 5'd7,  32'h12345000, {3'd5, 7'h37, 3'd0, 7'h00}, 1'b0);
      tinst[8]  = 32'hFE20AC23; texp[8]  = mk(3'd2, 5'd1, 5'd2, 5'd0,  32'hFFFFFFF8, {3'd2, 7'h23, 3'd2, 7'h00}, 1'b0);
      tinst[9]  = 32'h4030D213; texp[9]  = mk(3'd1, 5'd1, 5'd0, 5'd4,  32'h00000403, {3'd1, 7'h13, 3'd5, 7'h20}, 1'b0);
      tinst[10] = 32'h000280E7; texp[10] = mk(3'd1, 5'd5, 5'd0, 5'd1,  32'h00000000, {3'd1, 7'h67, 3'd0, 7'h00}, 1'b0);
      tinst[11] = 32'hFFFFF517; texp[11] = mk(3'd5, 5'd0, 5'd0, 5'd10, 32'hFFFFF000, {3'd5, 7'h17, 3'd0, 7'h00}, 1'b0);
      tinst[12] = 32'h00412303; texp[12] = mk(3'd1, 5'd2, 5'd0, 5'd6,  32'h00000004, {3'd1, 7'h03, 3'd2, 7'h00}, 1'b0);

      rst = 1'b1; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b0;
      rand_rdy = 1'b0; cur_exp = '0;
      repeat (2) step();
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_imm", imm, 0);
      check("rst_control", control_out, 0);
      check("rst_rd", rd, 0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1);

      // one-cycle latency, then hold after the FIFO drains
      send(0);
      check("lat_out_valid", out_valid, 1);
      check("lat_count", count, 1);
      check("lat_imm", imm, 32'hFFFFFFFF);
      check("lat_inst_type", inst_type, 1);
      out_ready = 1'b1;
      step();
      check("hold_out_valid", out_valid, 0);
      check("hold_imm", imm, 32'hFFFFFFFF);
      check("hold_rd", rd, 5);
      out_ready = 1'b0;

      // full table with random consumer back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 13; i++)
         send(i);
      drain();

      // back-pressure: third instruction held by fetch
      out_ready = 1'b0;
      send(1);
      send(2);
      inst = tinst[3]; cur_exp = texp[3]; in_valid = 1'b1;
      #1;
      check("full_count", count, 2);
      check("full_in_ready", in_ready, 0);
      step();
      check("full_hold_count", count, 2);
      out_ready = 1'b1;
      step();
      check("pop1_count", count, 1);
      check("pop1_in_ready", in_ready, 1);
      step();
      check("pushpop_count", count, 1);
      in_valid = 1'b0;
      step();
      check("bp_empty_count", count, 0);

      // flush on a full FIFO with a pending push
      out_ready = 1'b0;
      send(4);
      send(5);
      inst = tinst[6]; cur_exp = texp[6]; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("flush_count", count, 0);
      check("flush_out_valid", out_valid, 0);
      step();
      check("flush_discard", count, 0);

      // flush overrides a push that would otherwise be accepted
      send(7);
      inst = tinst[8]; cur_exp = texp[8]; in_valid = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_push_count", count, 0);
      check("flush_push_valid", out_valid, 0);
      send(9);
      drain();

      // reset while full
      out_ready = 1'b0;
      send(10);
      send(11);
      check("pre_rst_count", count, 2);
      rst = 1'b1;
      step();
      check("rst2_count", count, 0);
      check("rst2_out_valid", out_valid, 0);
      check("rst2_imm", imm, 0);
      check("rst2_control", control_out, 0);
      check("rst2_rd", rd, 0);
      check("rst2_illegal", illegal, 0);
      check("rst2_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("rst2_in_ready_after", in_ready, 1);
      send(12);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
